// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, bit positions, WARL masks and read-value packing helpers
// for the machine-mode CSR file.
package csr_file_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS_ADDR   = 12'h300,
    CSR_MISA_ADDR      = 12'h301,
    CSR_MIE_ADDR       = 12'h304,
    CSR_MTVEC_ADDR     = 12'h305,
    CSR_MSCRATCH_ADDR  = 12'h340,
    CSR_MEPC_ADDR      = 12'h341,
    CSR_MCAUSE_ADDR    = 12'h342,
    CSR_MTVAL_ADDR     = 12'h343,
    CSR_MIP_ADDR       = 12'h344,
    CSR_MCYCLE_ADDR    = 12'hB00,
    CSR_MINSTRET_ADDR  = 12'hB02,
    CSR_MCYCLEH_ADDR   = 12'hB80,
    CSR_MINSTRETH_ADDR = 12'hB82,
    CSR_MHARTID_ADDR   = 12'hF14
  } csr_addr_e;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIP_MSIP_BIT     = 3;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;

  // RV32I: MXL=1 in [31:30], extension I in bit 8
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;
  localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

  // MPP is hardwired to machine mode (2'b11 at bits 12:11)
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'h0000_1800;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

  function automatic logic [31:0] irq_pack(input logic ext, input logic tim, input logic sw);
    logic [31:0] v;
    v = 32'h0000_0000;
    v[MIP_MEIP_BIT] = ext;
    v[MIP_MTIP_BIT] = tim;
    v[MIP_MSIP_BIT] = sw;
    return v;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access port between EXU (master) and the CSR file (slave):
// combinational read plus a single registered write port.
interface csr_file_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;

  modport master (
    output csr_raddr, csr_we, csr_waddr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_raddr, csr_we, csr_waddr, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable 32-bit halves; a write to
// either half suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] count_r;

  // Counter state: software load has priority over the increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= 64'd0;
    end else if (we_lo) begin
      count_r[31:0] <= wdata;
    end else if (we_hi) begin
      count_r[63:32] <= wdata;
    end else if (inc) begin
      count_r <= count_r + 64'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign value = count_r;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: EXU read/write, trap/mret side effects,
// interrupt synchronisers. Optional 64-bit mcycle/minstret under `CSR_COUNTERS_EN.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  csr_file_if.slave        csr,
  input  logic             set_cause_i,
  input  logic             ie_type_i,
  input  logic [3:0]       trap_cause_i,
  input  logic             set_epc_i,
  input  logic [31:0]      epc_i,
  input  logic             set_mtval_i,
  input  logic [31:0]      mtval_i,
  input  logic             mstatus_ie_clear_i,
  input  logic             mstatus_ie_set_i,
  input  logic             irq_external_i,
  input  logic             irq_timer_i,
  input  logic             irq_software_i,
  input  logic             instret_i,
  output logic             mstatus_ie_o,
  output logic             mie_external_o,
  output logic             mie_timer_o,
  output logic             mie_sw_o,
  output logic             mip_external_o,
  output logic             mip_timer_o,
  output logic             mip_sw_o,
  output logic [31:0]      mtvec_o,
  output logic [31:0]      epc_o
);

  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic [2:0]  mie_r;          // {external, timer, software}
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [2:0]  irq_meta_r;
  logic [2:0]  irq_sync_r;

  logic        we_mstatus_s;
  logic        we_mie_s;
  logic        we_mtvec_s;
  logic        we_mscratch_s;
  logic        we_mepc_s;
  logic        we_mcause_s;
  logic        we_mtval_s;
  logic [31:0] rdata_s;
  logic        illegal_s;

`ifdef CSR_COUNTERS_EN
  logic        we_mcycle_s;
  logic        we_mcycleh_s;
  logic        we_minstret_s;
  logic        we_minstreth_s;
  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;
`else
  logic        unused_instret_s;
  assign unused_instret_s = instret_i;
`endif

  // Write-port address decode; read-only and unimplemented addresses decode to nothing
  always_comb begin
    we_mstatus_s  = 1'b0;
    we_mie_s      = 1'b0;
    we_mtvec_s    = 1'b0;
    we_mscratch_s = 1'b0;
    we_mepc_s     = 1'b0;
    we_mcause_s   = 1'b0;
    we_mtval_s    = 1'b0;
`ifdef CSR_COUNTERS_EN
    we_mcycle_s    = 1'b0;
    we_mcycleh_s   = 1'b0;
    we_minstret_s  = 1'b0;
    we_minstreth_s = 1'b0;
`endif
    if (csr.csr_we) begin
      case (csr.csr_waddr)
        CSR_MSTATUS_ADDR:   we_mstatus_s   = 1'b1;
        CSR_MIE_ADDR:       we_mie_s       = 1'b1;
        CSR_MTVEC_ADDR:     we_mtvec_s     = 1'b1;
        CSR_MSCRATCH_ADDR:  we_mscratch_s  = 1'b1;
        CSR_MEPC_ADDR:      we_mepc_s      = 1'b1;
        CSR_MCAUSE_ADDR:    we_mcause_s    = 1'b1;
        CSR_MTVAL_ADDR:     we_mtval_s     = 1'b1;
`ifdef CSR_COUNTERS_EN
        CSR_MCYCLE_ADDR:    we_mcycle_s    = 1'b1;
        CSR_MCYCLEH_ADDR:   we_mcycleh_s   = 1'b1;
        CSR_MINSTRET_ADDR:  we_minstret_s  = 1'b1;
        CSR_MINSTRETH_ADDR: we_minstreth_s = 1'b1;
`endif
        default:            we_mstatus_s   = 1'b0;
      endcase
    end else begin
      we_mstatus_s = 1'b0;
    end
  end

  // mstatus MIE/MPIE: trap entry beats mret, and both beat a software write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
    end else if (mstatus_ie_clear_i) begin
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (mstatus_ie_set_i) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (we_mstatus_s) begin
      mstatus_mie_r  <= csr.csr_wdata[MSTATUS_MIE_BIT];
      mstatus_mpie_r <= csr.csr_wdata[MSTATUS_MPIE_BIT];
    end else begin
      mstatus_mie_r  <= mstatus_mie_r;
      mstatus_mpie_r <= mstatus_mpie_r;
    end
  end

  // Software-only CSRs: mie, mtvec, mscratch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_r      <= 3'd0;
      mtvec_r    <= MTVEC_RESET;
      mscratch_r <= 32'd0;
    end else begin
      if (we_mie_s) begin
        mie_r <= {csr.csr_wdata[MIP_MEIP_BIT], csr.csr_wdata[MIP_MTIP_BIT],
                  csr.csr_wdata[MIP_MSIP_BIT]};
      end else begin
        mie_r <= mie_r;
      end
      if (we_mtvec_s) begin
        mtvec_r <= csr.csr_wdata & MTVEC_WMASK;
      end else begin
        mtvec_r <= mtvec_r;
      end
      if (we_mscratch_s) begin
        mscratch_r <= csr.csr_wdata;
      end else begin
        mscratch_r <= mscratch_r;
      end
    end
  end

  // Trap CSRs: the pipeline controller's side effect beats a same-cycle software write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mepc_r   <= 32'd0;
      mcause_r <= 32'd0;
      mtval_r  <= 32'd0;
    end else begin
      if (set_epc_i) begin
        mepc_r <= epc_i & MEPC_WMASK;
      end else if (we_mepc_s) begin
        mepc_r <= csr.csr_wdata & MEPC_WMASK;
      end else begin
        mepc_r <= mepc_r;
      end
      if (set_cause_i) begin
        mcause_r <= {ie_type_i, 27'd0, trap_cause_i};
      end else if (we_mcause_s) begin
        mcause_r <= csr.csr_wdata;
      end else begin
        mcause_r <= mcause_r;
      end
      if (set_mtval_i) begin
        mtval_r <= mtval_i;
      end else if (we_mtval_s) begin
        mtval_r <= csr.csr_wdata;
      end else begin
        mtval_r <= mtval_r;
      end
    end
  end

  // Two-flop synchronisers for the asynchronous interrupt lines; mip is the second stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_meta_r <= 3'd0;
      irq_sync_r <= 3'd0;
    end else begin
      irq_meta_r <= {irq_external_i, irq_timer_i, irq_software_i};
      irq_sync_r <= irq_meta_r;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (1'b1),
    .we_lo (we_mcycle_s),
    .we_hi (we_mcycleh_s),
    .wdata (csr.csr_wdata),
    .value (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (instret_i),
    .we_lo (we_minstret_s),
    .we_hi (we_minstreth_s),
    .wdata (csr.csr_wdata),
    .value (minstret_s)
  );
`endif

  // Combinational read mux; no write bypass
  always_comb begin
    rdata_s   = 32'd0;
    illegal_s = 1'b0;
    case (csr.csr_raddr)
      CSR_MSTATUS_ADDR:   rdata_s = mstatus_pack(mstatus_mie_r, mstatus_mpie_r);
      CSR_MISA_ADDR:      rdata_s = MISA_VALUE;
      CSR_MIE_ADDR:       rdata_s = irq_pack(mie_r[2], mie_r[1], mie_r[0]);
      CSR_MTVEC_ADDR:     rdata_s = mtvec_r;
      CSR_MSCRATCH_ADDR:  rdata_s = mscratch_r;
      CSR_MEPC_ADDR:      rdata_s = mepc_r;
      CSR_MCAUSE_ADDR:    rdata_s = mcause_r;
      CSR_MTVAL_ADDR:     rdata_s = mtval_r;
      CSR_MIP_ADDR:       rdata_s = irq_pack(irq_sync_r[2], irq_sync_r[1], irq_sync_r[0]);
      CSR_MHARTID_ADDR:   rdata_s = MHARTID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE_ADDR:    rdata_s = mcycle_s[31:0];
      CSR_MCYCLEH_ADDR:   rdata_s = mcycle_s[63:32];
      CSR_MINSTRET_ADDR:  rdata_s = minstret_s[31:0];
      CSR_MINSTRETH_ADDR: rdata_s = minstret_s[63:32];
`endif
      default: begin
        rdata_s   = 32'd0;
        illegal_s = 1'b1;
      end
    endcase
  end

  assign csr.csr_rdata   = rdata_s;
  assign csr.csr_illegal = illegal_s;

  assign mstatus_ie_o   = mstatus_mie_r;
  assign mie_external_o = mie_r[2];
  assign mie_timer_o    = mie_r[1];
  assign mie_sw_o       = mie_r[0];
  assign mip_external_o = irq_sync_r[2];
  assign mip_timer_o    = irq_sync_r[1];
  assign mip_sw_o       = irq_sync_r[0];
  assign mtvec_o        = mtvec_r;
  assign epc_o          = mepc_r;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic
// against a behavioural model of the CSR state (counters follow CSR_COUNTERS_EN).
module tb_csr_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        set_cause_i, ie_type_i, set_epc_i, set_mtval_i;
  logic [3:0]  trap_cause_i;
  logic [31:0] epc_i, mtval_i;
  logic        mstatus_ie_clear_i, mstatus_ie_set_i;
  logic        irq_external_i, irq_timer_i, irq_software_i, instret_i;
  logic        mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o;
  logic        mip_external_o, mip_timer_o, mip_sw_o;
  logic [31:0] mtvec_o, epc_o;

  int checks = 0;
  int errors = 0;

  csr_file_if bus ();

  csr_file dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr(bus),
    .set_cause_i(set_cause_i), .ie_type_i(ie_type_i), .trap_cause_i(trap_cause_i),
    .set_epc_i(set_epc_i), .epc_i(epc_i), .set_mtval_i(set_mtval_i), .mtval_i(mtval_i),
    .mstatus_ie_clear_i(mstatus_ie_clear_i), .mstatus_ie_set_i(mstatus_ie_set_i),
    .irq_external_i(irq_external_i), .irq_timer_i(irq_timer_i), .irq_software_i(irq_software_i),
    .instret_i(instret_i), .mstatus_ie_o(mstatus_ie_o),
    .mie_external_o(mie_external_o), .mie_timer_o(mie_timer_o), .mie_sw_o(mie_sw_o),
    .mip_external_o(mip_external_o), .mip_timer_o(mip_timer_o), .mip_sw_o(mip_sw_o),
    .mtvec_o(mtvec_o), .epc_o(epc_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic        m_mie, m_mpie;
  logic [2:0]  m_ie;            // {ext, timer, sw}
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;
  logic [2:0]  m_stage1, m_mip; // irq delay line, two edges deep

  logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB80,
                                 12'hB02, 12'hB82, 12'h7C0, 12'h000};

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_ie = 3'd0;
    m_mtvec = 32'd0; m_mscratch = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
    m_cyc = 64'd0; m_ins = 64'd0; m_stage1 = 3'd0; m_mip = 3'd0;
  endtask

  function automatic logic [32:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      12'h300: begin v = 32'h0000_1800; v[3] = m_mie; v[7] = m_mpie; end
      12'h301: v = 32'h4000_0100;
      12'h304: begin v[11] = m_ie[2]; v[7] = m_ie[1]; v[3] = m_ie[0]; end
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: begin v[11] = m_mip[2]; v[7] = m_mip[1]; v[3] = m_mip[0]; end
      12'hF14: v = 32'd0;
`ifdef CSR_COUNTERS_EN
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
`endif
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, v};
  endfunction

  task automatic drive_idle();
    bus.csr_raddr = 12'h000; bus.csr_we = 1'b0; bus.csr_waddr = 12'h000; bus.csr_wdata = 32'd0;
    set_cause_i = 1'b0; ie_type_i = 1'b0; trap_cause_i = 4'd0; set_epc_i = 1'b0; epc_i = 32'd0;
    set_mtval_i = 1'b0; mtval_i = 32'd0; mstatus_ie_clear_i = 1'b0; mstatus_ie_set_i = 1'b0;
    instret_i = 1'b0;
  endtask

  // One clock edge: model next state from the applied inputs, then advance to edge + 1
  task automatic tick();
    logic        n_mie, n_mpie, cyc_wr, ins_wr;
    logic [2:0]  n_ie;
    logic [31:0] n_mtvec, n_scr, n_epc, n_cause, n_tval, wd;
    logic [63:0] n_cyc, n_ins;
    n_mie = m_mie; n_mpie = m_mpie; n_ie = m_ie; n_mtvec = m_mtvec; n_scr = m_mscratch;
    n_epc = m_mepc; n_cause = m_mcause; n_tval = m_mtval; n_cyc = m_cyc; n_ins = m_ins;
    cyc_wr = 1'b0; ins_wr = 1'b0; wd = bus.csr_wdata;
    if (bus.csr_we) begin
      case (bus.csr_waddr)
        12'h300: begin n_mie = wd[3]; n_mpie = wd[7]; end
        12'h304: n_ie = {wd[11], wd[7], wd[3]};
        12'h305: n_mtvec = {wd[31:2], 1'b0, wd[0]};
        12'h340: n_scr = wd;
        12'h341: n_epc = {wd[31:2], 2'b00};
        12'h342: n_cause = wd;
        12'h343: n_tval = wd;
`ifdef CSR_COUNTERS_EN
        12'hB00: begin n_cyc[31:0] = wd; cyc_wr = 1'b1; end
        12'hB80: begin n_cyc[63:32] = wd; cyc_wr = 1'b1; end
        12'hB02: begin n_ins[31:0] = wd; ins_wr = 1'b1; end
        12'hB82: begin n_ins[63:32] = wd; ins_wr = 1'b1; end
`endif
        default: ;
      endcase
    end
    if (set_epc_i)   n_epc = {epc_i[31:2], 2'b00};
    if (set_cause_i) n_cause = {ie_type_i, 27'd0, trap_cause_i};
    if (set_mtval_i) n_tval = mtval_i;
    if (mstatus_ie_clear_i) begin n_mpie = m_mie; n_mie = 1'b0; end
    else if (mstatus_ie_set_i) begin n_mie = m_mpie; n_mpie = 1'b1; end
    if (!cyc_wr) n_cyc = m_cyc + 64'd1;
    if (!ins_wr && instret_i) n_ins = m_ins + 64'd1;
    @(posedge clk_i);
    #1;
    m_mie = n_mie; m_mpie = n_mpie; m_ie = n_ie; m_mtvec = n_mtvec; m_mscratch = n_scr;
    m_mepc = n_epc; m_mcause = n_cause; m_mtval = n_tval; m_cyc = n_cyc; m_ins = n_ins;
    m_mip = m_stage1; m_stage1 = {irq_external_i, irq_timer_i, irq_software_i};
  endtask

  task automatic test_reset();
    rst_i = 1'b1; drive_idle();
    irq_external_i = 1'b0; irq_timer_i = 1'b0; irq_software_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0; model_reset();
    #1;
    checks++;
    if ({mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o, mip_external_o, mip_timer_o, mip_sw_o} !== 7'd0) begin
      errors++; $display("FAIL reset_bits got %b exp 0000000",
        {mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o, mip_external_o, mip_timer_o, mip_sw_o});
    end
    checks++;
    if (mtvec_o !== 32'd0 || epc_o !== 32'd0) begin
      errors++; $display("FAIL reset_vec mtvec=%h epc=%h exp 0/0", mtvec_o, epc_o);
    end
    bus.csr_raddr = 12'h300; #1;
    checks++;
    if (bus.csr_rdata !== 32'h0000_1800 || bus.csr_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_mstatus got %h/%b exp 00001800/0", bus.csr_rdata, bus.csr_illegal);
    end
    bus.csr_raddr = 12'h301; #1;
    checks++;
    if (bus.csr_rdata !== 32'h4000_0100) begin
      errors++; $display("FAIL misa got %h exp 40000100", bus.csr_rdata);
    end
    bus.csr_raddr = 12'h7C0; #1;
    checks++;
    if (bus.csr_rdata !== 32'd0 || bus.csr_illegal !== 1'b1) begin
      errors++; $display("FAIL unimpl_read got %h/%b exp 0/1", bus.csr_rdata, bus.csr_illegal);
    end
  endtask

  task automatic test_mtvec();
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h305; bus.csr_wdata = 32'h8000_0103;
    bus.csr_raddr = 12'h305; #1;
    checks++;
    if (bus.csr_rdata !== 32'd0) begin
      errors++; $display("FAIL mtvec_no_bypass got %h exp 00000000", bus.csr_rdata);
    end
    tick();
    bus.csr_we = 1'b0; #1;
    checks++;
    if (mtvec_o !== 32'h8000_0101 || bus.csr_rdata !== 32'h8000_0101) begin
      errors++; $display("FAIL mtvec_warl out=%h rd=%h exp 80000101", mtvec_o, bus.csr_rdata);
    end
  endtask

  task automatic test_mstatus();
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h300; bus.csr_wdata = 32'hFFFF_FF7F;
    tick();
    bus.csr_we = 1'b0; bus.csr_raddr = 12'h300; #1;
    checks++;
    if (bus.csr_rdata !== 32'h0000_1808 || mstatus_ie_o !== 1'b1) begin
      errors++; $display("FAIL mstatus_wr got %h/%b exp 00001808/1", bus.csr_rdata, mstatus_ie_o);
    end
    mstatus_ie_clear_i = 1'b1; tick(); mstatus_ie_clear_i = 1'b0; #1;
    checks++;
    if (bus.csr_rdata !== 32'h0000_1880 || mstatus_ie_o !== 1'b0) begin
      errors++; $display("FAIL ie_clear got %h/%b exp 00001880/0", bus.csr_rdata, mstatus_ie_o);
    end
    mstatus_ie_set_i = 1'b1; tick(); mstatus_ie_set_i = 1'b0; #1;
    checks++;
    if (bus.csr_rdata !== 32'h0000_1888 || mstatus_ie_o !== 1'b1) begin
      errors++; $display("FAIL ie_set got %h/%b exp 00001888/1", bus.csr_rdata, mstatus_ie_o);
    end
    mstatus_ie_clear_i = 1'b1; mstatus_ie_set_i = 1'b1;
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h300; bus.csr_wdata = 32'h0000_0008;
    tick();
    mstatus_ie_clear_i = 1'b0; mstatus_ie_set_i = 1'b0; bus.csr_we = 1'b0; #1;
    checks++;
    if (bus.csr_rdata !== 32'h0000_1880 || mstatus_ie_o !== 1'b0) begin
      errors++; $display("FAIL clr_wins got %h/%b exp 00001880/0", bus.csr_rdata, mstatus_ie_o);
    end
  endtask

  task automatic test_trap_priority();
    set_cause_i = 1'b1; set_epc_i = 1'b1; ie_type_i = 1'b1; trap_cause_i = 4'hB; epc_i = 32'h0000_0106;
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h342; bus.csr_wdata = 32'h1234_5678;
    tick();
    bus.csr_waddr = 12'h341; bus.csr_wdata = 32'hFFFF_FFFF; set_cause_i = 1'b0;
    tick();
    drive_idle(); bus.csr_raddr = 12'h342; #1;
    checks++;
    if (bus.csr_rdata !== 32'h8000_000B) begin
      errors++; $display("FAIL trap_mcause got %h exp 8000000B", bus.csr_rdata);
    end
    bus.csr_raddr = 12'h341; #1;
    checks++;
    if (bus.csr_rdata !== 32'h0000_0104 || epc_o !== 32'h0000_0104) begin
      errors++; $display("FAIL trap_mepc rd=%h out=%h exp 00000104", bus.csr_rdata, epc_o);
    end
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h343; bus.csr_wdata = 32'hAAAA_0000;
    set_mtval_i = 1'b1; mtval_i = 32'h0000_BEEF;
    set_cause_i = 1'b0; bus.csr_raddr = 12'h343;
    tick();
    drive_idle(); bus.csr_raddr = 12'h343; #1;
    checks++;
    if (bus.csr_rdata !== 32'h0000_BEEF) begin
      errors++; $display("FAIL trap_mtval got %h exp 0000BEEF", bus.csr_rdata);
    end
  endtask

  task automatic test_irq_sync();
    logic exp_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    irq_timer_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) irq_timer_i = 1'b0;
      tick();
      checks++;
      if (mip_timer_o !== exp_seq[i]) begin
        errors++; $display("FAIL irq_sync edge%0d got %b exp %b", i, mip_timer_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    bus.csr_we = 1'b1; bus.csr_waddr = 12'hB00; bus.csr_wdata = 32'hFFFF_FFFE; tick();
    bus.csr_waddr = 12'hB80; bus.csr_wdata = 32'd0; tick();
    bus.csr_we = 1'b0; tick(); tick();
    bus.csr_raddr = 12'hB80; #1;
    checks++;
    if (bus.csr_rdata !== 32'd1) begin
      errors++; $display("FAIL mcycleh got %h exp 00000001", bus.csr_rdata);
    end
    bus.csr_raddr = 12'hB00; #1;
    checks++;
    if (bus.csr_rdata !== 32'd0 || bus.csr_illegal !== 1'b0) begin
      errors++; $display("FAIL mcycle got %h/%b exp 0/0", bus.csr_rdata, bus.csr_illegal);
    end
    bus.csr_we = 1'b1; bus.csr_waddr = 12'hB02; bus.csr_wdata = 32'hFFFF_FFFF; instret_i = 1'b1; tick();
    bus.csr_we = 1'b0; tick(); instret_i = 1'b0; tick();
    bus.csr_raddr = 12'hB82; #1;
    checks++;
    if (bus.csr_rdata !== 32'd1) begin
      errors++; $display("FAIL minstreth got %h exp 00000001", bus.csr_rdata);
    end
    bus.csr_raddr = 12'hB02; #1;
    checks++;
    if (bus.csr_rdata !== 32'd0) begin
      errors++; $display("FAIL minstret got %h exp 00000000", bus.csr_rdata);
    end
`else
    bus.csr_we = 1'b1; bus.csr_waddr = 12'hB00; bus.csr_wdata = 32'h1234_5678; tick();
    bus.csr_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.csr_raddr = addr_tab[10 + i]; #1;
      checks++;
      if (bus.csr_rdata !== 32'd0 || bus.csr_illegal !== 1'b1) begin
        errors++; $display("FAIL counter_absent addr=%h got %h/%b exp 0/1", addr_tab[10 + i], bus.csr_rdata, bus.csr_illegal);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [32:0] exp_rd;
    logic [70:0] exp_out, got_out;
    for (int n = 0; n < 400; n++) begin
      bus.csr_we = ($urandom_range(0, 1) == 1);
      bus.csr_waddr = addr_tab[$urandom_range(0, 15)];
      bus.csr_wdata = $urandom;
      bus.csr_raddr = addr_tab[$urandom_range(0, 15)];
      set_cause_i = ($urandom_range(0, 7) == 0); ie_type_i = $urandom_range(0, 1);
      trap_cause_i = 4'($urandom_range(0, 15));
      set_epc_i = ($urandom_range(0, 7) == 0); epc_i = $urandom;
      set_mtval_i = ($urandom_range(0, 7) == 0); mtval_i = $urandom;
      mstatus_ie_clear_i = ($urandom_range(0, 5) == 0);
      mstatus_ie_set_i = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) irq_external_i = ~irq_external_i;
      if ($urandom_range(0, 3) == 0) irq_timer_i = ~irq_timer_i;
      if ($urandom_range(0, 3) == 0) irq_software_i = ~irq_software_i;
      instret_i = $urandom_range(0, 1);
      #1;
      exp_rd = model_read(bus.csr_raddr);
      checks++;
      if (bus.csr_rdata !== exp_rd[31:0] || bus.csr_illegal !== exp_rd[32]) begin
        errors++; $display("FAIL rand_read #%0d addr=%h got %h/%b exp %h/%b", n, bus.csr_raddr,
                           bus.csr_rdata, bus.csr_illegal, exp_rd[31:0], exp_rd[32]);
      end
      tick();
      exp_out = {m_mie, m_ie, m_mip, m_mtvec, m_mepc};
      got_out = {mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o,
                 mip_external_o, mip_timer_o, mip_sw_o, mtvec_o, epc_o};
      checks++;
      if (got_out !== exp_out) begin
        errors++; $display("FAIL rand_outputs #%0d got %h exp %h", n, got_out, exp_out);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h305; bus.csr_wdata = 32'hCAFE_F00C; tick();
    bus.csr_waddr = 12'h304; bus.csr_wdata = 32'hFFFF_FFFF; tick();
    bus.csr_we = 1'b0; irq_external_i = 1'b1; irq_timer_i = 1'b1; irq_software_i = 1'b1;
    tick(); tick();
    rst_i = 1'b1; #2;
    checks++;
    if ({mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o, mip_external_o, mip_timer_o, mip_sw_o} !== 7'd0
        || mtvec_o !== 32'd0 || epc_o !== 32'd0) begin
      errors++; $display("FAIL midreset_outputs mtvec=%h epc=%h ie=%b mie=%b%b%b mip=%b%b%b exp all 0",
        mtvec_o, epc_o, mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o,
        mip_external_o, mip_timer_o, mip_sw_o);
    end
    bus.csr_raddr = 12'h304; #1;
    checks++;
    if (bus.csr_rdata !== 32'd0) begin
      errors++; $display("FAIL midreset_mie got %h exp 00000000", bus.csr_rdata);
    end
    rst_i = 1'b0; irq_external_i = 1'b0; irq_timer_i = 1'b0; irq_software_i = 1'b0;
    model_reset();
    bus.csr_raddr = 12'h305; tick(); #1;
    checks++;
    if (mtvec_o !== 32'd0 || bus.csr_rdata !== 32'd0) begin
      errors++; $display("FAIL postreset_mtvec got %h/%h exp 0", mtvec_o, bus.csr_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_mtvec();
    test_mstatus();
    test_trap_priority();
    test_irq_sync();
    test_counters();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
